// File: rtl/c_writeback_collector.sv
// c_writeback_collector: gathers per-lane mesh output elements into TILEUNITS-wide tiles
// and issues one-cycle tile writes with tile-aligned addresses to the block memory C port.
// Ports:
//   clock, reset                  single clock, synchronous active-high reset
//   cmd_valid/cmd_ready           start handshake (ready only in IDLE)
//   cmd_base_addr, cmd_tiles      first tile address (low bits masked), tiles per lane
//   in_valid/in_data/in_ready     per-lane element stream, lane i at in_data[i*BITWIDTH +: BITWIDTH]
//   C                             tile data, lane i element j at C[(i*TILEUNITS+j)*BITWIDTH +: BITWIDTH]
//   C_tile_write_addrs            per-lane tile address, lane i at [i*BITWIDTH +: BITWIDTH]
//   C_write_valid                 per-lane one-cycle write strobe
//   busy, done, overflow          status: collecting/draining, completion pulse, sticky drop flag
// Optional feature: define C_WRITEBACK_RELU_EN to clamp negative elements to zero on capture.
module c_writeback_collector #(
    parameter int BITWIDTH = 16,
    parameter int MESHUNITS = 4,
    parameter int TILEUNITS = 4,
    parameter int CNTW = 8
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     cmd_valid,
    output logic                                     cmd_ready,
    input  logic [BITWIDTH-1:0]                      cmd_base_addr,
    input  logic [CNTW-1:0]                          cmd_tiles,
    input  logic [MESHUNITS-1:0]                     in_valid,
    input  logic [MESHUNITS*BITWIDTH-1:0]            in_data,
    output logic [MESHUNITS-1:0]                     in_ready,
    output logic [MESHUNITS*TILEUNITS*BITWIDTH-1:0]  C,
    output logic [MESHUNITS*BITWIDTH-1:0]            C_tile_write_addrs,
    output logic [MESHUNITS-1:0]                     C_write_valid,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     overflow
);
    localparam int IW = $clog2(TILEUNITS);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

    state_t                state, state_d;
    logic [BITWIDTH-1:0]   base_q;
    logic [CNTW-1:0]       tiles_q;
    logic                  start;
    logic [MESHUNITS-1:0]  fin_soon;

    assign cmd_ready = state == IDLE;
    assign start     = cmd_ready && cmd_valid;
    assign busy      = state == COLLECT || state == DRAIN;
    assign done      = state == DONE;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            base_q   <= '0;
            tiles_q  <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_d;
            if (start) begin
                base_q   <= cmd_base_addr & ~BITWIDTH'(TILEUNITS - 1);
                tiles_q  <= cmd_tiles;
                overflow <= 1'b0;
            end else if (busy && |(in_valid & ~in_ready)) begin
                overflow <= 1'b1;
            end
        end
    end

    // Leave COLLECT in the same cycle the last lane accepts its final element,
    // so DRAIN coincides with the final write strobe.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (cmd_valid) state_d = (cmd_tiles == '0) ? DONE : COLLECT;
            COLLECT: if (&fin_soon) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    for (genvar g = 0; g < MESHUNITS; g++) begin : g_lane
        logic [IW-1:0]                 idx;
        logic [CNTW-1:0]               tiles;
        logic [BITWIDTH-1:0]           din, elem, addr_q;
        logic [BITWIDTH-1:0]           tbuf [TILEUNITS];
        logic [TILEUNITS*BITWIDTH-1:0] c_q;
        logic                          wv_q, acc, last;

        assign din = in_data[g*BITWIDTH +: BITWIDTH];
`ifdef C_WRITEBACK_RELU_EN
        assign elem = din[BITWIDTH-1] ? '0 : din;
`else
        assign elem = din;
`endif
        assign in_ready[g] = state == COLLECT && tiles != tiles_q;
        assign acc         = in_ready[g] && in_valid[g];
        assign last        = idx == IW'(TILEUNITS - 1);
        assign fin_soon[g] = tiles == tiles_q || (acc && last && tiles + CNTW'(1) == tiles_q);

        always_ff @(posedge clock) begin
            if (acc) tbuf[idx] <= elem;
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                idx    <= '0;
                tiles  <= '0;
                c_q    <= '0;
                addr_q <= '0;
                wv_q   <= 1'b0;
            end else begin
                wv_q <= acc && last;
                if (start) begin
                    idx   <= '0;
                    tiles <= '0;
                end else if (acc) begin
                    idx <= idx + IW'(1);
                    if (last) begin
                        tiles <= tiles + CNTW'(1);
                        for (int j = 0; j < TILEUNITS - 1; j++) c_q[j*BITWIDTH +: BITWIDTH] <= tbuf[j];
                        c_q[(TILEUNITS-1)*BITWIDTH +: BITWIDTH] <= elem;
                        addr_q <= base_q + BITWIDTH'((32'(tiles) * MESHUNITS + g) * TILEUNITS);
                    end
                end
            end
        end

        assign C[g*TILEUNITS*BITWIDTH +: TILEUNITS*BITWIDTH] = c_q;
        assign C_tile_write_addrs[g*BITWIDTH +: BITWIDTH]    = addr_q;
        assign C_write_valid[g]                              = wv_q;
    end
endmodule

// File: tb/tb_c_writeback_collector.sv
// tb_c_writeback_collector: randomized and directed bench for c_writeback_collector against a tile-level model.
module tb_c_writeback_collector;
    localparam int BW = 16, M = 2, T = 4, CW = 8;

    logic              clock = 0, reset = 1, cmd_valid = 0, cmd_ready;
    logic [BW-1:0]     cmd_base_addr = '0;
    logic [CW-1:0]     cmd_tiles = '0;
    logic [M-1:0]      in_valid = '0, in_ready, C_write_valid;
    logic [M*BW-1:0]   in_data = '0, C_tile_write_addrs;
    logic [M*T*BW-1:0] C;
    logic              busy, done, overflow;

    always #5 clock = ~clock;

    c_writeback_collector #(.BITWIDTH(BW), .MESHUNITS(M), .TILEUNITS(T), .CNTW(CW)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base_addr(cmd_base_addr), .cmd_tiles(cmd_tiles), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .C(C), .C_tile_write_addrs(C_tile_write_addrs),
        .C_write_valid(C_write_valid), .busy(busy), .done(done), .overflow(overflow)
    );

    int total = 0, bad = 0;

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: phase 0 idle, 1 collecting, 2 final-write cycle, 3 done pulse.
    int              ph, m_tiles, nwr;
    int              m_cnt [M];
    logic [BW-1:0]   m_base;
    logic [BW-1:0]   m_buf [M][T];
    logic [T*BW-1:0] e_c [M];
    logic [BW-1:0]   e_a [M];
    logic [M-1:0]    e_wv;
    logic            e_ovf;
    logic [T*BW-1:0] obs_c0;
    logic [BW-1:0]   obs_a0, obs_a1;
    logic [BW-1:0]   pat [T] = '{16'hFFFD, 16'h0005, 16'hFFFF, 16'h0000};

    function automatic logic [BW-1:0] cap(logic [BW-1:0] v);
`ifdef C_WRITEBACK_RELU_EN
        return v[BW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic model_reset();
        ph = 0; m_tiles = 0; e_wv = '0; e_ovf = 0;
        for (int i = 0; i < M; i++) begin
            m_cnt[i] = 0; e_c[i] = '0; e_a[i] = '0;
        end
    endtask

    task automatic cycle();
        int np;
        bit all_fin;
        #1;
        for (int i = 0; i < M; i++) check("in_ready", in_ready[i], ph == 1 && m_cnt[i] < m_tiles * T);
        check("cmd_ready", cmd_ready, ph == 0);
        check("busy", busy, ph == 1 || ph == 2);
        e_wv = '0;
        np = ph;
        if (ph == 0) begin
            if (cmd_valid) begin
                m_base = cmd_base_addr & ~16'(T - 1);
                m_tiles = int'(cmd_tiles);
                for (int i = 0; i < M; i++) m_cnt[i] = 0;
                e_ovf = 0;
                np = (m_tiles == 0) ? 3 : 1;
            end
        end else if (ph == 1 || ph == 2) begin
            all_fin = 1;
            for (int i = 0; i < M; i++) begin
                if (in_valid[i]) begin
                    if (ph == 1 && m_cnt[i] < m_tiles * T) begin
                        m_buf[i][m_cnt[i] % T] = cap(in_data[i*BW +: BW]);
                        m_cnt[i]++;
                        if (m_cnt[i] % T == 0) begin
                            e_wv[i] = 1;
                            for (int j = 0; j < T; j++) e_c[i][j*BW +: BW] = m_buf[i][j];
                            e_a[i] = m_base + BW'(((m_cnt[i] / T - 1) * M + i) * T);
                        end
                    end else e_ovf = 1;
                end
                if (m_cnt[i] < m_tiles * T) all_fin = 0;
            end
            np = (ph == 2) ? 3 : (all_fin ? 2 : 1);
        end else np = 0;
        ph = np;
        @(posedge clock);
        #1;
        check("write_valid", C_write_valid, e_wv);
        for (int i = 0; i < M; i++) if (e_wv[i]) begin
            check("tile_data", C[i*T*BW +: T*BW], e_c[i]);
            check("tile_addr", C_tile_write_addrs[i*BW +: BW], e_a[i]);
        end
        check("done", done, ph == 3);
        check("overflow", overflow, e_ovf);
        if (C_write_valid[0]) begin obs_c0 = C[0 +: T*BW]; obs_a0 = C_tile_write_addrs[0 +: BW]; end
        if (C_write_valid[1]) obs_a1 = C_tile_write_addrs[BW +: BW];
        nwr += $countones(C_write_valid);
    endtask

    task automatic reset_cycle();
        reset = 1;
        @(posedge clock);
        #1;
        reset = 0; cmd_valid = 0; in_valid = '0;
        model_reset();
        check("rst_wv", C_write_valid, 0);
        check("rst_C", C, 0);
        check("rst_addr", C_tile_write_addrs, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", overflow, 0);
        #1 check("rst_in_ready", in_ready, 0);
    endtask

    // mode 0: stream while needed; 1: lane0 always valid, lane1 stalls 10 cycles;
    // 2: random valid/data; 3: signed pattern stream
    task automatic run(logic [BW-1:0] base, int tiles, int mode);
        cmd_base_addr = base; cmd_tiles = CW'(tiles); cmd_valid = 1; in_valid = '0;
        cycle();
        cmd_valid = 0;
        for (int c = 0; c < 400 && ph != 0; c++) begin
            for (int i = 0; i < M; i++) begin
                in_valid[i] = m_cnt[i] < m_tiles * T;
                in_data[i*BW +: BW] = BW'(m_cnt[i] + 1);
                if (mode == 1) in_valid[i] = (i == 0) ? 1'b1 : (c >= 10 && m_cnt[i] < m_tiles * T);
                if (mode == 2) begin
                    in_valid[i] = 1'($urandom_range(0, 1));
                    in_data[i*BW +: BW] = BW'($urandom);
                    cmd_valid = 1'($urandom_range(0, 1));
                    cmd_base_addr = BW'($urandom);
                end
                if (mode == 3) in_data[i*BW +: BW] = pat[m_cnt[i] % T];
            end
            cycle();
        end
        cmd_valid = 0; in_valid = '0;
        check("back_to_idle", cmd_ready, 1);
    endtask

    initial begin
        int w0;
        nwr = 0;
        reset_cycle();
        run(16'h0040, 2, 0);
        check("t1_addr", obs_a0, 16'h0048);
        check("t1_data", obs_c0, {16'd8, 16'd7, 16'd6, 16'd5});
        check("t1_lane1_addr", obs_a1, 16'h004C);
        run(16'h0043, 1, 0);
        check("mask_addr", obs_a1, 16'h0044);
        run(16'h0200, 2, 1);
        check("ovf_sticky", overflow, 1);
        run(16'hFFF8, 2, 0);
        check("wrap_lane0", obs_a0, 16'h0000);
        check("wrap_lane1", obs_a1, 16'h0004);
        w0 = nwr;
        run(16'h1234, 0, 0);
        check("zero_tiles_writes", nwr, w0);
        cmd_base_addr = 16'h0100; cmd_tiles = 1; cmd_valid = 1;
        cycle();
        cmd_valid = 0;
        for (int c = 0; c < 3; c++) begin
            in_valid = '1;
            for (int i = 0; i < M; i++) in_data[i*BW +: BW] = 16'h0AA0;
            cycle();
        end
        in_valid = '1;
        reset_cycle();
        run(16'h0100, 1, 0);
        check("restart_data", obs_c0, {16'd4, 16'd3, 16'd2, 16'd1});
        run(16'h0000, 1, 3);
`ifdef C_WRITEBACK_RELU_EN
        check("relu_tile", obs_c0, {16'h0000, 16'h0000, 16'h0005, 16'h0000});
`else
        check("raw_tile", obs_c0, {16'h0000, 16'hFFFF, 16'h0005, 16'hFFFD});
`endif
        for (int r = 0; r < 20; r++) run(BW'($urandom), $urandom_range(0, 5), 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/c_writeback_collector.md
# c_writeback_collector

Downstream stage between the systolic mesh outputs and the block memory's C write port. Gathers the per-lane element stream leaving the mesh into TILEUNITS-wide tiles, computes tile-aligned write addresses from a programmed base, and issues one-cycle tile writes (`C`, `C_tile_write_addrs`, `C_write_valid`) that the block memory commits on the next clock edge. One command per matrix result; a `done` pulse marks completion.

## Interface
- `BITWIDTH`, 16: element and address width.
- `MESHUNITS`, 4: number of independent lanes; one write port per lane.
- `TILEUNITS`, 4: elements per tile; power of two, ≥2.
- `CNTW`, 8: width of the tile-count field.

- `clock`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  start request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_base_addr`  in  BITWIDTH  first tile address; low log2(TILEUNITS) bits ignored (treated as 0).
- `cmd_tiles`  in  CNTW  tiles to collect per lane.
- `in_valid`  in  [MESHUNITS] x 1  element valid per lane.
- `in_data`  in  [MESHUNITS] x BITWIDTH signed  element per lane.
- `in_ready`  out  [MESHUNITS] x 1  lane accepts this cycle.
- `C`  out  [MESHUNITS][TILEUNITS] x BITWIDTH signed  tile data.
- `C_tile_write_addrs`  out  [MESHUNITS] x BITWIDTH  tile-aligned address.
- `C_write_valid`  out  [MESHUNITS] x 1  one-cycle write strobe.
- `busy`  out  1  high in COLLECT or DRAIN.
- `done`  out  1  one-cycle completion pulse.
- `overflow`  out  1  sticky: element offered to a finished lane.

## Operation
- States: IDLE → COLLECT → DRAIN → DONE → IDLE.
- IDLE: `cmd_ready`=1. `cmd_valid` accepted → latch base (masked) and count, clear per-lane element/tile counters, clear `overflow`, go COLLECT; if `cmd_tiles`=0 go DONE directly (no writes).
- COLLECT: `in_ready[i]`=1 while lane i has completed fewer than `cmd_tiles` tiles. Accepted element placed at `C[i][j]`, j = per-lane element index 0..TILEUNITS-1 in arrival order. On the TILEUNITS-th element, lane i's tile moves to its output register, index resets, tile count increments.
- Address for lane i, tile k: base + (k·MESHUNITS + i)·TILEUNITS, modulo 2^BITWIDTH (wrap silently).
- Lanes are independent; any lane may stall (`in_valid`=0) arbitrarily; no inter-lane ordering.
- Lane finished and `in_valid[i]`=1: element dropped, `in_ready[i]`=0, `overflow` set.
- All lanes finished → DRAIN (one cycle, final writes visible) → DONE (`done`=1 one cycle) → IDLE.
- `cmd_valid` outside IDLE ignored.

## Timing
- Last element of a tile accepted in cycle t → `C_write_valid[i]`=1 in cycle t+1 only, with `C[i]` and address stable that cycle. Back-to-back tiles per lane at full rate: no bubbles.
- Final tile accepted cycle t → DRAIN at t+1 (write strobe), `done` at t+2, `cmd_ready` at t+3.
- Command accepted cycle t → `in_ready` high at t+1.
- Reset values: `cmd_ready`=1 (IDLE), `in_ready`=0, `C_write_valid`=0, `C`=0, `C_tile_write_addrs`=0, `busy`=0, `done`=0, `overflow`=0.
- Reset mid-operation: partial tiles discarded; no `C_write_valid` in the cycle after reset even if a tile completed the cycle of reset.
- Outputs when `C_write_valid[i]`=0 are don't-care to consumer but hold last value.

## Configuration
- `C_WRITEBACK_RELU_EN` defined: each element clamped to 0 if negative when captured into the tile (ReLU); ±0 and positives unchanged.
- Undefined: elements stored bit-exact. No other behaviour differs; latency identical.

## Test plan
- MESHUNITS=2, TILEUNITS=4, base=0x0040, tiles=2, both lanes stream 1..8 continuously → writes lane0 @0x40 {1,2,3,4}, @0x48 {5,6,7,8}; lane1 @0x44, @0x4C; `done` 2 cycles after last write-strobe-causing element.
- base=0x0043 → treated as 0x0040; lane1 tile0 address 0x0044.
- Lane0 streams, lane1 stalls 10 cycles then streams → lane0 writes unaffected; `done` only after lane1's second tile.
- Extra element on lane0 after its 2 tiles → `in_ready[0]`=0, `overflow`=1 until next accepted command; no extra write.
- base=0xFFF8, tiles=2, MESHUNITS=2 → tile k=1 lane0 address 0x0000 (wrap); `cmd_tiles`=0 → `done` one cycle after accept, no writes.
- Assert `reset` mid-tile then restart → no stale write; with `C_WRITEBACK_RELU_EN`, input {-3,5,-1,0} writes {0,5,0,0}; without, {-3,5,-1,0}.
